hilo_unit: RTL

- Owns the architectural HI/LO register pair read by the execute stage through hi_o/lo_o.
- Accepts HI/LO write-back from the WB end of the pipeline: a 64-bit product from MULT/MULTU, or single-word MTHI/MTLO.
- Contains a multi-cycle iterative divider for DIV/DIVU. It stalls the execute stage while running and writes its quotient and remainder straight into LO/HI.

---
 rtl/mips_cpu_pkg.sv | 28 ++
 rtl/hilo_unit_div_core.sv | 120 ++++++++++++
 rtl/hilo_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: datapath word widths, the divider FSM encoding and the HI/LO write-back bundle.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_cpu_pkg;

   localparam int WIDTH_REG = 32;
   localparam int DIV_ITER  = 32;
   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

   typedef logic [WIDTH_REG-1:0]   reg_t;
   typedef logic [2*WIDTH_REG-1:0] double_reg_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_enum;

   // One write-back beat towards HI/LO: paired product write or single-word MTHI/MTLO.
   typedef struct packed {
      logic        hilowe;
      logic        hiwe;
      logic        lowe;
      double_reg_t hilo;
      reg_t        wdata;
   } hilo_wr_t;

endpackage

// File: rtl/hilo_unit_div_core.sv
// Iterative restoring divider (signed/unsigned) with start/flush/done handshake.
// Latency: 1 start cycle + DIV_ITER calc cycles + 1 done cycle; divide-by-zero skips calc.
// Backpressure: start is taken only in IDLE; flush aborts CALC/DONE and suppresses done_vld.
// Ports: clk/rst_n (sync, active-low); start/flush/sgn/dividend/divisor in;
//        start_acc, calc_act, busy, done_vld, quot, rem out (quot/rem valid with done_vld).
module div_core #(
   parameter int WIDTH_REG = mips_cpu_pkg::WIDTH_REG,
   parameter int DIV_ITER  = mips_cpu_pkg::DIV_ITER
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 flush,
   input  logic                 sgn,
   input  logic [WIDTH_REG-1:0] dividend,
   input  logic [WIDTH_REG-1:0] divisor,
   output logic                 start_acc,
   output logic                 calc_act,
   output logic                 busy,
   output logic                 done_vld,
   output logic [WIDTH_REG-1:0] quot,
   output logic [WIDTH_REG-1:0] rem
);
   import mips_cpu_pkg::*;

   localparam int CNT_W = $clog2(DIV_ITER);

   div_state_enum state_q, state_d;

   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH_REG-1:0] rem_q, quot_q, dvs_q;
   logic                 neg_quot_q, neg_rem_q;

   logic                 a_neg, b_neg, div_zero, last_iter;
   logic [WIDTH_REG-1:0] a_abs, b_abs;
   logic [WIDTH_REG:0]   trial, diff;

   assign a_neg     = sgn & dividend[WIDTH_REG-1];
   assign b_neg     = sgn & divisor[WIDTH_REG-1];
   assign a_abs     = a_neg ? (~dividend + 1'b1) : dividend;
   assign b_abs     = b_neg ? (~divisor + 1'b1) : divisor;
   assign div_zero  = (divisor == '0);
   assign last_iter = (cnt_q == CNT_W'(DIV_ITER - 1));

   // Trial remainder keeps the bit shifted out of rem: it can reach WIDTH_REG+1 bits.
   // A clear borrow bit in diff means trial >= divisor.
   assign trial = {rem_q, quot_q[WIDTH_REG-1]};
   assign diff  = trial - {1'b0, dvs_q};

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) state_d = div_zero ? DONE : CALC;
         end
         CALC: begin
            if (flush)          state_d = IDLE;
            else if (last_iter) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      start_acc = (state_q == IDLE) && start && !flush;
      calc_act  = (state_q == CALC);
      busy      = (state_q != IDLE);
      done_vld  = (state_q == DONE) && !flush;
   end

   // Shift/subtract datapath and iteration counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         dvs_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
      end else if (start_acc) begin
         cnt_q <= '0;
         dvs_q <= b_abs;
         if (div_zero) begin
            // Raw dividend as remainder, all-ones quotient, no sign fix-up.
            rem_q      <= dividend;
            quot_q     <= WIDTH_REG'(DIV_BY_ZERO_Q);
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
         end else begin
            rem_q      <= '0;
            quot_q     <= a_abs;
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
         end
      end else if (state_q == CALC) begin
         cnt_q <= cnt_q + 1'b1;
         if (!diff[WIDTH_REG]) begin
            rem_q  <= diff[WIDTH_REG-1:0];
            quot_q <= {quot_q[WIDTH_REG-2:0], 1'b1};
         end else begin
            rem_q  <= trial[WIDTH_REG-1:0];
            quot_q <= {quot_q[WIDTH_REG-2:0], 1'b0};
         end
      end
   end

   // Sign fix-up; 0x80000000 / -1 wraps naturally to 0x80000000.
   assign quot = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
   assign rem  = neg_rem_q  ? (~rem_q + 1'b1)  : rem_q;

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO register pair with WB write-back and an attached iterative divider.
// Latency: WB writes visible the cycle after the strobe; divide result visible after DONE.
// Backpressure: stall_o held from divide start through CALC; dropped in DONE or on flush.
// Ports: cpu_clk_50M/cpu_rst_n (sync, active-low); wb_i_* write-back; div_* divide request;
//        stall_o, div_busy_o, hi_o, lo_o out.
module hilo_unit #(
   parameter int WIDTH_REG = mips_cpu_pkg::WIDTH_REG,
   parameter int DIV_ITER  = mips_cpu_pkg::DIV_ITER
) (
   input  logic                   cpu_clk_50M,
   input  logic                   cpu_rst_n,
   input  logic                   wb_i_hilowe,
   input  logic [2*WIDTH_REG-1:0] wb_i_hilo,
   input  logic                   wb_i_hiwe,
   input  logic                   wb_i_lowe,
   input  logic [WIDTH_REG-1:0]   wb_i_wdata,
   input  logic                   div_start,
   input  logic                   div_signed,
   input  logic [WIDTH_REG-1:0]   div_dividend,
   input  logic [WIDTH_REG-1:0]   div_divisor,
   input  logic                   div_flush,
   output logic                   stall_o,
   output logic                   div_busy_o,
   output logic [WIDTH_REG-1:0]   hi_o,
   output logic [WIDTH_REG-1:0]   lo_o
);
   import mips_cpu_pkg::*;

   hilo_wr_t wb_wr;

   logic                 start_acc, calc_act, done_vld;
   logic [WIDTH_REG-1:0] div_quot, div_rem;
   logic [WIDTH_REG-1:0] hi_q, lo_q;

   assign wb_wr = '{hilowe: wb_i_hilowe, hiwe: wb_i_hiwe, lowe: wb_i_lowe,
                    hilo: wb_i_hilo, wdata: wb_i_wdata};

   div_core #(
      .WIDTH_REG (WIDTH_REG),
      .DIV_ITER  (DIV_ITER)
   ) u_div_core (
      .clk       (cpu_clk_50M),
      .rst_n     (cpu_rst_n),
      .start     (div_start),
      .flush     (div_flush),
      .sgn       (div_signed),
      .dividend  (div_dividend),
      .divisor   (div_divisor),
      .start_acc (start_acc),
      .calc_act  (calc_act),
      .busy      (div_busy_o),
      .done_vld  (done_vld),
      .quot      (div_quot),
      .rem       (div_rem)
   );

   // Stall covers the accepting IDLE cycle and every CALC cycle; a flush releases it at once.
   assign stall_o = start_acc | (calc_act & ~div_flush);

   // Divider result is younger than anything in WB, so it overrides WB writes.
   // Within WB, the paired product write beats the single-word strobes.
   always_ff @(posedge cpu_clk_50M) begin
      if (!cpu_rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (done_vld) begin
         hi_q <= div_rem;
         lo_q <= div_quot;
      end else begin
         if (wb_wr.hilowe)    hi_q <= wb_wr.hilo[2*WIDTH_REG-1:WIDTH_REG];
         else if (wb_wr.hiwe) hi_q <= wb_wr.wdata;
         if (wb_wr.hilowe)    lo_q <= wb_wr.hilo[WIDTH_REG-1:0];
         else if (wb_wr.lowe) lo_q <= wb_wr.wdata;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule
